// File: rtl/lif_layer_tm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lif_layer_tm_pkg                                           |
// | Brief   : Shared types for the time-multiplexed LIF neuron layer     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lif_layer_tm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } fsm_state_t;

  typedef enum logic {
    RST_ZERO = 1'b0,
    RST_SUB  = 1'b1
  } reset_mode_t;

endpackage
`default_nettype wire

// File: rtl/lif_layer_tm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lif_layer_tm_if                                            |
// | Brief   : Host-side bus of the LIF layer (step, currents, monitor)   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface lif_layer_tm_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic          step;
  logic [W-1:0]  thr;
  logic          cur_we;
  logic [IW-1:0] cur_idx;
  logic [W-1:0]  cur_data;
  logic          busy;
  logic          done;
  logic [N-1:0]  spikes;
  logic [IW-1:0] mon_idx;
  logic [W-1:0]  mon_state;

  // Host side
  modport master (
    output step, thr, cur_we, cur_idx, cur_data, mon_idx,
    input  busy, done, spikes, mon_state
  );

  // Layer side
  modport slave (
    input  step, thr, cur_we, cur_idx, cur_data, mon_idx,
    output busy, done, spikes, mon_state
  );
endinterface
`default_nettype wire

// File: rtl/lif_layer_tm_update_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lif_update_core                                            |
// | Brief   : Combinational single-neuron leak/integrate/fire datapath   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lif_update_core
  import lif_layer_tm_pkg::*;
#(
  parameter int W          = 8,
  parameter int BETA_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  i_v,
  input  logic [W-1:0]  i_c,
  input  logic [RW-1:0] i_r,
  input  logic [W-1:0]  i_thr,
  output logic [W-1:0]  o_v_next,
  output logic [RW-1:0] o_r_next,
  output logic          o_spike
);
  localparam logic [RW-1:0] c_REFRAC = RW'(REFRAC);
  localparam reset_mode_t   c_MODE   = reset_mode_t'(RESET_MODE[0]);

  logic [W-1:0] w_leaked;
  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;

  // Leak, saturating integrate, then threshold/refractory decision
  always_comb begin
    w_leaked = i_v - (i_v >> BETA_SHIFT);
    w_sum    = {1'b0, w_leaked} + {1'b0, i_c};
    w_sat    = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    o_v_next = '0;
    o_r_next = '0;
    o_spike  = 1'b0;
    if (i_r != '0) begin
      // Refractory: membrane held at zero, input current ignored
      o_r_next = i_r - RW'(1);
    end else if (w_sat >= i_thr) begin
      o_spike  = 1'b1;
      o_v_next = (c_MODE == RST_SUB) ? (w_sat - i_thr) : '0;
      o_r_next = c_REFRAC;
    end else begin
      o_v_next = w_sat;
    end
  end
endmodule
`default_nettype wire

// File: rtl/lif_layer_tm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lif_layer_tm                                               |
// | Brief   : N-neuron LIF layer, one shared update datapath swept       |
// |           across neurons one per cycle; atomic spike publication     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lif_layer_tm
  import lif_layer_tm_pkg::*;
#(
  parameter int N          = 8,
  parameter int W          = 8,
  parameter int BETA_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0,
  parameter int CUR_CLEAR  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  lif_layer_tm_if.slave bus
);
  localparam int              c_IW   = $clog2(N);
  localparam int              c_RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

  fsm_state_t      r_state;
  logic [c_IW-1:0] r_idx;
  logic [W-1:0]    r_thr;
  logic [N-1:0]    r_shadow;
  logic [N-1:0]    r_spikes;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_mon;
  logic [W-1:0]    r_mem [N];
  logic [W-1:0]    r_cur [N];
  logic [c_RW-1:0] r_ref [N];

  logic [W-1:0]    w_v_next;
  logic [c_RW-1:0] w_r_next;
  logic            w_spike;

  lif_update_core #(
    .W          (W),
    .BETA_SHIFT (BETA_SHIFT),
    .REFRAC     (REFRAC),
    .RESET_MODE (RESET_MODE),
    .RW         (c_RW)
  ) u_core (
    .i_v      (r_mem[r_idx]),
    .i_c      (r_cur[r_idx]),
    .i_r      (r_ref[r_idx]),
    .i_thr    (r_thr),
    .o_v_next (w_v_next),
    .o_r_next (w_r_next),
    .o_spike  (w_spike)
  );

  // Sweep FSM: owns membranes, refractory counters, shadow and published spikes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_thr    <= '0;
      r_shadow <= '0;
      r_spikes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
        r_ref[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.step) begin
            r_state <= UPDATE;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_thr   <= bus.thr;
          end
        end
        UPDATE: begin
          r_mem[r_idx]    <= w_v_next;
          r_ref[r_idx]    <= w_r_next;
          r_shadow[r_idx] <= w_spike;
          if (r_idx == c_LAST) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + c_IW'(1);
          end
        end
        DONE: begin
          // Publish the whole step at once so the host never sees a partial vector
          r_spikes <= r_shadow;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Current registers: optional clear-after-use, host write placed last so it wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_cur[i] <= '0;
      end
    end else begin
      if ((CUR_CLEAR != 0) && (r_state == UPDATE)) begin
        r_cur[r_idx] <= '0;
      end
      if (bus.cur_we && (int'(bus.cur_idx) < N)) begin
        r_cur[bus.cur_idx] <= bus.cur_data;
      end
    end
  end

  // Membrane monitor, bypassing the value being written this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mon <= '0;
    end else if (int'(bus.mon_idx) >= N) begin
      r_mon <= '0;
    end else if ((r_state == UPDATE) && (bus.mon_idx == r_idx)) begin
      r_mon <= w_v_next;
    end else begin
      r_mon <= r_mem[bus.mon_idx];
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.spikes    = r_spikes;
  assign bus.mon_state = r_mon;
endmodule
`default_nettype wire
